// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver with majority vote, break detection and receive FIFO
module uart_rx_fifo #(
    parameter int CLK_FREQ       = 100,
    parameter int BAUD_DIV_WIDTH = 16,
    parameter int OVERSAMPLE     = 16,
    parameter int FIFO_DEPTH     = 16,
    parameter int DATA_BITS_MAX  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BAUD_DIV_WIDTH-1:0]     baud_div,
    input  logic [1:0]                    data_type,
    input  logic [1:0]                    stop_type,
    input  logic                          check_en,
    input  logic [1:0]                    check_type,
    input  logic                          en,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS_MAX+1:0]      rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          break_det,
    output logic                          busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_V2  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    if (CLK_FREQ < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DATA_BITS_MAX != 8) begin : g_bad_param
        $error("uart_rx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRKWAIT} state_t;
    state_t state, state_d;

    logic                      rx_meta, rx_sync, rx_prev;
    logic [BAUD_DIV_WIDTH-1:0] presc;
    logic [SW-1:0]             samp;
    logic                      v0, v1;
    logic [2:0]                bit_cnt;
    logic [DATA_BITS_MAX-1:0]  shreg;
    logic                      parity_err_q, frame_err_q, any_one;
    logic                      push, brk_now;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    logic       start_det, tick, vote_now, bit_end, vote, two_stop, par_exp;
    logic       frame_done, frame_err_fin, is_break;
    logic [2:0] last_data;

    assign start_det     = en && rx_prev && !rx_sync;
    assign tick          = (state != IDLE) && (presc == baud_div);
    assign vote_now      = tick && (samp == S_V2);
    assign bit_end       = tick && (samp == S_END);
    assign vote          = (v0 & v1) | (v0 & rx_sync) | (v1 & rx_sync);
    assign last_data     = 3'd7 - {1'b0, data_type};
    assign two_stop      = (stop_type == 2'b10);
    // The final stop bit closes the frame at its vote so the next start edge is never missed.
    assign frame_done    = (state == STOP) && vote_now && (!two_stop || bit_cnt == 3'd1);
    assign frame_err_fin = frame_err_q | ~vote;
    // With two stop bits frame_err_q holds exactly the first stop vote at completion time.
    assign is_break      = !any_one && (two_stop ? frame_err_q : ~vote);

    always_comb begin
        case (check_type)
            2'b00:   par_exp = ~^shreg;
            2'b01:   par_exp = ^shreg;
            2'b10:   par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (state != IDLE && !en) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_det) state_d = START;
                START:   if (vote_now && vote) state_d = IDLE;
                         else if (bit_end) state_d = DATA;
                DATA:    if (bit_end && bit_cnt == last_data) state_d = check_en ? PARITY : STOP;
                PARITY:  if (bit_end) state_d = STOP;
                STOP:    if (frame_done) state_d = is_break ? BRKWAIT : IDLE;
                BRKWAIT: if (rx_sync) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state != IDLE);
        push    = frame_done && !is_break && en;
        brk_now = frame_done && is_break && en;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc        <= '0;
            samp         <= '0;
            v0           <= 1'b1;
            v1           <= 1'b1;
            bit_cnt      <= '0;
            shreg        <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            any_one      <= 1'b0;
        end else if (state == IDLE) begin
            presc        <= '0;
            samp         <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            any_one      <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                samp <= (samp == S_END) ? '0 : samp + 1'b1;
                if (samp == S_V0) v0 <= rx_sync;
                if (samp == S_V1) v1 <= rx_sync;
            end
            if (vote_now) begin
                case (state)
                    DATA: begin
                        shreg[bit_cnt] <= vote;
                        any_one        <= any_one | vote;
                    end
                    PARITY: begin
                        parity_err_q <= (vote != par_exp);
                        any_one      <= any_one | vote;
                    end
                    STOP:    frame_err_q <= frame_err_q | ~vote;
                    default: ;
                endcase
            end
            if (bit_end) begin
                if (state == DATA) bit_cnt <= (bit_cnt == last_data) ? 3'd0 : bit_cnt + 3'd1;
                else if (state == STOP) bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    logic [DATA_BITS_MAX+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              count;
    logic                     full, pop, wr;

    assign full = (count == DEPTH_C);
    assign pop  = rd_en && (count != '0);
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr && !pop)      count <= count + 1'b1;
            else if (!wr && pop) count <= count - 1'b1;
            overrun   <= push && full && !pop;
            break_det <= brk_now;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {parity_err_q, frame_err_fin, shreg};
    end

    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [1:0]  data_type, stop_type, check_type;
    logic        check_en, en, rx, rd_en;
    logic [9:0]  rd_data;
    logic        rd_valid, overrun, break_det, busy;
    logic [2:0]  fifo_count;

    int vectors = 0, miscompares = 0;
    int ovr_cnt = 0, brk_cnt = 0, bit_clk = 0;

    uart_rx_fifo #(.CLK_FREQ(100), .BAUD_DIV_WIDTH(16), .OVERSAMPLE(OS),
                   .FIFO_DEPTH(DEPTH), .DATA_BITS_MAX(8)) dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .data_type(data_type),
        .stop_type(stop_type), .check_en(check_en), .check_type(check_type),
        .en(en), .rx(rx), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_count(fifo_count), .overrun(overrun), .break_det(break_det), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun)   ovr_cnt++;
        if (break_det) brk_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_baud(input int bd);
        baud_div = 16'(bd);
        bit_clk  = OS * (bd + 1);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (bit_clk) @(negedge clk);
    endtask

    // Final stop bit optionally pulses rd_en in the cycle the receiver pushes the frame.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                              input logic par, input int nstop, input logic s2, input bit pop_last);
        int voff;
        logic last;
        voff = 2 + int'(baud_div + 1) * (OS / 2 + 2);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par);
        last = 1'b1;
        if (nstop == 2) begin
            drive_bit(1'b1);
            last = s2;
        end
        rx = last;
        for (int c = 0; c < bit_clk; c++) begin
            rd_en = pop_last && (c == voff);
            @(negedge clk);
        end
        rd_en = 1'b0;
        rx    = 1'b1;
    endtask

    task automatic pop_head(output logic [9:0] d, output logic v);
        d     = rd_data;
        v     = rd_valid;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if ({busy, rd_valid, rd_data, fifo_count, overrun, break_det} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b rd_valid=%b rd_data=%h count=%0d ovr=%b brk=%b, expected all 0",
                     busy, rd_valid, rd_data, fifo_count, overrun, break_det);
        end
    endtask

    task automatic test_8n1;
        logic [7:0] d;
        logic [9:0] got;
        logic       v;
        d = 8'hA5;
        set_baud(53);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        rx = 1'b1;
        repeat (540) @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL 8n1_early_valid: rd_valid=%b, expected 0 before stop vote", rd_valid);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 10'h0A5 || fifo_count !== 3'd1) begin
            miscompares++;
            $display("FAIL 8n1_push: rd_valid=%b rd_data=%h count=%0d, expected 1 0a5 1",
                     rd_valid, rd_data, fifo_count);
        end
        repeat (bit_clk - 545) @(negedge clk);
        pop_head(got, v);
        vectors++;
        if (fifo_count !== 3'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL 8n1_pop: count=%0d rd_valid=%b, expected 0 0", fifo_count, rd_valid);
        end
    endtask

    task automatic test_parity_frame;
        logic [9:0] got;
        logic       v;
        int         o0, b0;
        o0 = ovr_cnt; b0 = brk_cnt;
        set_baud(7);
        data_type = 2'b01; check_en = 1'b1; check_type = 2'b01; stop_type = 2'b10;
        send_frame(8'h3C, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
        send_frame(8'h3C, 7, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        drive_bit(1'b1);
        vectors++;
        if (fifo_count !== 3'd2 || ovr_cnt != o0 || brk_cnt != b0) begin
            miscompares++;
            $display("FAIL 7e2_count: count=%0d ovr=%0d brk=%0d, expected 2 %0d %0d",
                     fifo_count, ovr_cnt, brk_cnt, o0, b0);
        end
        pop_head(got, v);
        vectors++;
        if (v !== 1'b1 || got !== 10'h23C) begin
            miscompares++;
            $display("FAIL 7e2_parity_err: valid=%b data=%h, expected 1 23c", v, got);
        end
        pop_head(got, v);
        vectors++;
        if (v !== 1'b1 || got !== 10'h13C) begin
            miscompares++;
            $display("FAIL 7e2_frame_err: valid=%b data=%h, expected 1 13c", v, got);
        end
        data_type = 2'b00; check_en = 1'b0; check_type = 2'b00; stop_type = 2'b00;
    endtask

    task automatic test_glitch;
        int o0, b0;
        o0 = ovr_cnt; b0 = brk_cnt;
        set_baud(53);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_start: busy=%b, expected 1", busy);
        end
        repeat (200) @(negedge clk);
        rx = 1'b1;
        repeat (900) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || fifo_count !== 3'd0 || ovr_cnt != o0 || brk_cnt != b0) begin
            miscompares++;
            $display("FAIL glitch_reject: busy=%b count=%0d ovr=%0d brk=%0d, expected 0 0 %0d %0d",
                     busy, fifo_count, ovr_cnt, brk_cnt, o0, b0);
        end
    endtask

    task automatic test_overrun;
        logic [9:0] got;
        logic       v;
        int         o0;
        o0 = ovr_cnt;
        set_baud(7);
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        vectors++;
        if (fifo_count !== 3'd4 || ovr_cnt != o0 + 1) begin
            miscompares++;
            $display("FAIL overrun_full: count=%0d overruns=%0d, expected 4 %0d",
                     fifo_count, ovr_cnt - o0, 1);
        end
        for (int k = 1; k <= 4; k++) begin
            pop_head(got, v);
            vectors++;
            if (v !== 1'b1 || got !== 10'(k)) begin
                miscompares++;
                $display("FAIL overrun_order: valid=%b data=%h, expected 1 %h", v, got, 10'(k));
            end
        end
        for (int k = 8'h11; k <= 8'h14; k++) send_frame(8'(k), 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        send_frame(8'h15, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        vectors++;
        if (fifo_count !== 3'd4 || ovr_cnt != o0 + 1) begin
            miscompares++;
            $display("FAIL full_push_pop: count=%0d overruns=%0d, expected 4 1", fifo_count, ovr_cnt - o0);
        end
        for (int k = 8'h12; k <= 8'h15; k++) begin
            pop_head(got, v);
            vectors++;
            if (v !== 1'b1 || got !== 10'(k)) begin
                miscompares++;
                $display("FAIL full_push_pop_order: valid=%b data=%h, expected 1 %h", v, got, 10'(k));
            end
        end
    endtask

    task automatic test_break;
        logic [9:0] got;
        logic       v;
        int         b0;
        b0 = brk_cnt;
        set_baud(7);
        rx = 1'b0;
        repeat (20 * bit_clk) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || brk_cnt != b0 + 1 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL break_hold: busy=%b breaks=%0d count=%0d, expected 1 1 0",
                     busy, brk_cnt - b0, fifo_count);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL break_release: busy=%b, expected 0", busy);
        end
        drive_bit(1'b1);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        pop_head(got, v);
        vectors++;
        if (v !== 1'b1 || got !== 10'h055 || brk_cnt != b0 + 1) begin
            miscompares++;
            $display("FAIL break_next_frame: valid=%b data=%h breaks=%0d, expected 1 055 1",
                     v, got, brk_cnt - b0);
        end
    endtask

    task automatic test_abort;
        logic [9:0] got;
        logic       v;
        set_baud(7);
        send_frame(8'h42, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || fifo_count !== 3'd1) begin
            miscompares++;
            $display("FAIL abort_en: busy=%b count=%0d, expected 0 1", busy, fifo_count);
        end
        rx = 1'b1;
        repeat (2 * bit_clk) @(negedge clk);
        en = 1'b1;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        pop_head(got, v);
        vectors++;
        if (v !== 1'b1 || got !== 10'h042) begin
            miscompares++;
            $display("FAIL abort_kept: valid=%b data=%h, expected 1 042", v, got);
        end
        pop_head(got, v);
        vectors++;
        if (v !== 1'b1 || got !== 10'h081) begin
            miscompares++;
            $display("FAIL abort_next: valid=%b data=%h, expected 1 081", v, got);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] got;
        logic       v;
        set_baud(7);
        send_frame(8'h42, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, rd_valid, rd_data, fifo_count, overrun, break_det} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b rd_valid=%b rd_data=%h count=%0d ovr=%b brk=%b, expected all 0",
                     busy, rd_valid, rd_data, fifo_count, overrun, break_det);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (bit_clk) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b count=%0d, expected 0 0", busy, fifo_count);
        end
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        vectors++;
        if (fifo_count !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_next_count: count=%0d, expected 1", fifo_count);
        end
        pop_head(got, v);
        vectors++;
        if (v !== 1'b1 || got !== 10'h081) begin
            miscompares++;
            $display("FAIL reset_next_frame: valid=%b data=%h, expected 1 081", v, got);
        end
    endtask

    initial begin
        rst = 1'b0; rx = 1'b1; rd_en = 1'b0; en = 1'b0;
        data_type = 2'b00; stop_type = 2'b00; check_en = 1'b0; check_type = 2'b00;
        set_baud(53);
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b1;
        en  = 1'b1;
        repeat (4) @(negedge clk);
        test_8n1;
        test_parity_frame;
        test_glitch;
        test_overrun;
        test_break;
        test_abort;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
